// File: rtl/naval_pkg.sv
// naval_pkg: shared state, result and digit-index definitions for the naval board controller
package naval_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  typedef enum logic [1:0] {MISS = 2'd0, HIT = 2'd1, REPEAT = 2'd2, INVALID = 2'd3} result_t;
  localparam logic [1:0] DIG_STATE  = 2'd0;
  localparam logic [1:0] DIG_RESULT = 2'd1;
  localparam logic [1:0] DIG_COL    = 2'd2;
  localparam logic [1:0] DIG_ROW    = 2'd3;
endpackage

// File: rtl/naval_board_ctrl_if.sv
// naval_board_ctrl_if: game controls in, LED matrix / 7-seg / score out
interface naval_board_ctrl_if #(
  parameter int ROWS  = 7,
  parameter int COLS  = 5,
  parameter int CNT_W = 6
);
  logic                 load;
  logic [ROWS*COLS-1:0] ship_map;
  logic                 fire_btn;
  logic [2:0]           row_sel;
  logic [2:0]           col_sel;
  logic                 view_sel;
  logic [COLS-1:0]      m_col;
  logic [ROWS-1:0]      m_line;
  logic [3:0]           seg_val;
  logic [3:0]           seg_sel;
  logic [1:0]           result;
  logic [CNT_W-1:0]     shots;
  logic [CNT_W-1:0]     hits;
  logic                 game_over;
  modport master (
    output load, ship_map, fire_btn, row_sel, col_sel, view_sel,
    input  m_col, m_line, seg_val, seg_sel, result, shots, hits, game_over
  );
  modport slave (
    input  load, ship_map, fire_btn, row_sel, col_sel, view_sel,
    output m_col, m_line, seg_val, seg_sel, result, shots, hits, game_over
  );
endinterface

// File: rtl/naval_board_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer followed by a one-cycle rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic pulse
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], d};
  always_ff @(posedge clk or negedge clr)
    if (!clr) sh_q <= '0;
    else      sh_q <= sh_d;
  assign pulse = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/naval_board_ctrl.sv
// naval_board_ctrl: ship/shot maps, fire resolution, scoring and LED/7-seg multiplexing
module naval_board_ctrl
  import naval_pkg::*;
#(
  parameter int ROWS    = 7,
  parameter int COLS    = 5,
  parameter int DIV_W   = 20,
  parameter int BLINK_W = 3,
  parameter int CNT_W   = 6
) (
  input logic clk,
  input logic clr,
  naval_board_ctrl_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int TOT_W = $clog2(N + 1);
  localparam int MW    = CNT_W > TOT_W ? CNT_W : TOT_W;
  localparam int CI_W  = COLS > 1 ? $clog2(COLS) : 1;
  localparam int BW    = BLINK_W + 1;

  state_t            state_q, state_d;
  result_t           result_q, result_d;
  logic [N-1:0]      ship_q, ship_d, shot_q, shot_d, sel;
  logic [TOT_W-1:0]  total_q, total_d, pop;
  logic [CNT_W-1:0]  shots_q, shots_d, hits_q, hits_d;
  logic [DIV_W-1:0]  pre_q, pre_d;
  logic [CI_W-1:0]   col_q, col_d;
  logic [1:0]        dig_q, dig_d;
  logic [BW-1:0]     bl_q, bl_d;
  logic [COLS-1:0]   m_col_q, m_col_d;
  logic [ROWS-1:0]   m_line_q, m_line_d;
  logic [3:0]        seg_val_q, seg_val_d, seg_sel_q, seg_sel_d;
  logic              over_q, over_d, fire, tick, attack, ship_hit;

  btn_sync_edge u_fire (.clk(clk), .clr(clr), .d(bus.fire_btn), .pulse(fire));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ship_d   = ship_q;
    shot_d   = shot_q;
    total_d  = total_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    sel      = '0;
    pop      = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sel[r*COLS+c] = bus.row_sel == 3'(r) && bus.col_sel == 3'(c);
    for (int i = 0; i < N; i++)
      pop = pop + TOT_W'(bus.ship_map[i]);
    ship_hit = |(sel & ship_q);
    // load always wins over a coincident fire event
    if (bus.load && |bus.ship_map) begin
      state_d  = PLAY;
      result_d = MISS;
      ship_d   = bus.ship_map;
      shot_d   = '0;
      total_d  = pop;
      shots_d  = '0;
      hits_d   = '0;
    end else if (state_q == PLAY) begin
      if (MW'(hits_q) == MW'(total_q)) state_d = OVER;
      if (fire) begin
        if (!(|sel))                result_d = INVALID;
        else if (|(sel & shot_q))   result_d = REPEAT;
        else begin
          shot_d   = shot_q | sel;
          shots_d  = &shots_q ? shots_q : shots_q + CNT_W'(1);
          hits_d   = ship_hit && !(&hits_q) ? hits_q + CNT_W'(1) : hits_q;
          result_d = ship_hit ? HIT : MISS;
        end
      end
    end
    over_d = state_d == OVER;
  end

  always_comb begin
    tick      = &pre_q;
    pre_d     = pre_q + DIV_W'(1);
    col_d     = tick ? (col_q == CI_W'(COLS - 1) ? '0 : col_q + CI_W'(1)) : col_q;
    dig_d     = tick ? dig_q + 2'd1 : dig_q;
    bl_d      = tick ? bl_q + BW'(1) : bl_q;
    attack    = bus.view_sel | over_q;
    m_col_d   = '0;
    m_line_d  = '0;
    for (int c = 0; c < COLS; c++)
      if (col_q == CI_W'(c)) begin
        m_col_d[c] = 1'b1;
        for (int r = 0; r < ROWS; r++)
          m_line_d[r] = state_q == IDLE ? 1'b0 :
                        attack ? shot_q[r*COLS+c] & (ship_q[r*COLS+c] | bl_q[BW-1]) :
                        ship_q[r*COLS+c];
      end
    seg_val_d = dig_q == DIG_STATE  ? 4'(state_q)  :
                dig_q == DIG_RESULT ? 4'(result_q) :
                dig_q == DIG_COL    ? {1'b0, bus.col_sel} : {1'b0, bus.row_sel};
    seg_sel_d = 4'b0001 << dig_q;
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q   <= IDLE;
      result_q  <= MISS;
      ship_q    <= '0;
      shot_q    <= '0;
      total_q   <= '0;
      shots_q   <= '0;
      hits_q    <= '0;
      over_q    <= 1'b0;
      pre_q     <= '0;
      col_q     <= '0;
      dig_q     <= '0;
      bl_q      <= '0;
      m_col_q   <= COLS'(1);
      m_line_q  <= '0;
      seg_val_q <= '0;
      seg_sel_q <= 4'b0001;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      ship_q    <= ship_d;
      shot_q    <= shot_d;
      total_q   <= total_d;
      shots_q   <= shots_d;
      hits_q    <= hits_d;
      over_q    <= over_d;
      pre_q     <= pre_d;
      col_q     <= col_d;
      dig_q     <= dig_d;
      bl_q      <= bl_d;
      m_col_q   <= m_col_d;
      m_line_q  <= m_line_d;
      seg_val_q <= seg_val_d;
      seg_sel_q <= seg_sel_d;
    end

  assign bus.m_col     = m_col_q;
  assign bus.m_line    = m_line_q;
  assign bus.seg_val   = seg_val_q;
  assign bus.seg_sel   = seg_sel_q;
  assign bus.result    = result_q;
  assign bus.shots     = shots_q;
  assign bus.hits      = hits_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_naval_board_ctrl.sv
// tb_naval_board_ctrl: directed plus randomized checks against a cell-array game model
module tb_naval_board_ctrl;
  import naval_pkg::*;
  localparam int ROWS = 7, COLS = 5, CNT_W = 6, DIV_W = 4, BLINK_W = 1;
  localparam int N = ROWS * COLS, SCAN = 1 << DIV_W, MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0, clr = 1'b0;
  int   checks = 0, passed = 0, cyc = 0;
  bit   ship_m[ROWS][COLS], shot_m[ROWS][COLS];
  int   m_shots, m_hits, m_total, m_state, m_res;
  bit   seen0, seen1;

  naval_board_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();
  naval_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .BLINK_W(BLINK_W), .CNT_W(CNT_W))
    dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk or negedge clr)
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        ship_m[r][c] = 1'b0;
        shot_m[r][c] = 1'b0;
      end
    m_shots = 0; m_hits = 0; m_total = 0; m_state = 0; m_res = 0;
  endfunction

  function automatic void model_load(input logic [N-1:0] m);
    if (m == '0) return;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        ship_m[r][c] = m[r*COLS+c];
        shot_m[r][c] = 1'b0;
      end
    m_total = $countones(m);
    m_shots = 0; m_hits = 0; m_res = 0; m_state = 1;
  endfunction

  function automatic void model_fire(input int r, input int c);
    if (m_state != 1) return;
    if (r >= ROWS || c >= COLS) begin m_res = 3; return; end
    if (shot_m[r][c]) begin m_res = 2; return; end
    shot_m[r][c] = 1'b1;
    m_shots = m_shots < MAXC ? m_shots + 1 : MAXC;
    if (ship_m[r][c]) begin
      m_hits = m_hits < MAXC ? m_hits + 1 : MAXC;
      m_res = 1;
    end else m_res = 0;
    if (m_hits == m_total) m_state = 2;
  endfunction

  function automatic logic [ROWS-1:0] exp_line(input int col, input bit blink, input bit view);
    logic [ROWS-1:0] l = '0;
    for (int r = 0; r < ROWS; r++)
      l[r] = m_state == 0 ? 1'b0 :
             (view || m_state == 2) ? shot_m[r][col] & (ship_m[r][col] | blink) : ship_m[r][col];
    return l;
  endfunction

  task automatic check_scan(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int t, col, d;
      logic [3:0] sv;
      @(posedge clk); #1;
      t = (cyc - 1) / SCAN;
      col = t % COLS;
      d = t % 4;
      sv = d == 0 ? 4'(m_state) : d == 1 ? 4'(m_res) : d == 2 ? {1'b0, bus.col_sel} : {1'b0, bus.row_sel};
      chk({tag, " m_col"}, bus.m_col, 64'(1) << col);
      chk({tag, " seg_sel"}, bus.seg_sel, 64'(1) << d);
      chk({tag, " seg_val"}, bus.seg_val, sv);
      chk({tag, " m_line"}, bus.m_line, exp_line(col, 1'((t >> BLINK_W) & 1), bus.view_sel));
      if (bus.view_sel && bus.m_col == 5'b01000) begin
        if (bus.m_line[2]) seen1 = 1'b1;
        else seen0 = 1'b1;
      end
    end
  endtask

  task automatic fire(input logic [2:0] r, input logic [2:0] c, input int hold, input string tag);
    int pre_res;
    bit pre_over;
    bus.row_sel = r;
    bus.col_sel = c;
    @(negedge clk); bus.fire_btn = 1'b1;
    pre_res = m_res;
    pre_over = m_state == 2;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " result early"}, bus.result, pre_res);
    chk({tag, " shots early"}, bus.shots, m_shots);
    @(posedge clk); #1;
    model_fire(int'(r), int'(c));
    chk({tag, " result"}, bus.result, m_res);
    chk({tag, " shots"}, bus.shots, m_shots);
    chk({tag, " hits"}, bus.hits, m_hits);
    chk({tag, " game_over"}, bus.game_over, pre_over);
    @(posedge clk); #1;
    chk({tag, " game_over next"}, bus.game_over, m_state == 2);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({tag, " held shots"}, bus.shots, m_shots);
      chk({tag, " held result"}, bus.result, m_res);
    end
    @(negedge clk); bus.fire_btn = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_load(input logic [N-1:0] m, input string tag);
    @(negedge clk); bus.ship_map = m; bus.load = 1'b1;
    @(negedge clk); bus.load = 1'b0;
    model_load(m);
    chk({tag, " shots"}, bus.shots, m_shots);
    chk({tag, " hits"}, bus.hits, m_hits);
    chk({tag, " result"}, bus.result, m_res);
    chk({tag, " game_over"}, bus.game_over, m_state == 2);
    repeat (2) @(posedge clk);
  endtask

  task automatic fire_load(input logic [2:0] r, input logic [2:0] c, input logic [N-1:0] m);
    bus.row_sel = r;
    bus.col_sel = c;
    @(negedge clk); bus.fire_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); bus.ship_map = m; bus.load = 1'b1;
    @(negedge clk); bus.load = 1'b0; bus.fire_btn = 1'b0;
    model_load(m);
    chk("collide shots", bus.shots, m_shots);
    chk("collide hits", bus.hits, m_hits);
    chk("collide result", bus.result, m_res);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [N-1:0] m;
    bus.load = 1'b0; bus.ship_map = '0; bus.fire_btn = 1'b0;
    bus.row_sel = '0; bus.col_sel = '0; bus.view_sel = 1'b0;
    model_reset();
    #12;
    chk("rst m_col", bus.m_col, 1);
    chk("rst m_line", bus.m_line, 0);
    chk("rst seg_sel", bus.seg_sel, 1);
    chk("rst result", bus.result, 0);
    chk("rst shots", bus.shots, 0);
    chk("rst hits", bus.hits, 0);
    chk("rst game_over", bus.game_over, 0);
    #11 clr = 1'b1;
    fire(3'd0, 3'd0, 0, "idle fire");
    m = '0; m[0] = 1'b1; m[6] = 1'b1;
    do_load(m, "t1 load");
    check_scan(70, "t1 scan");
    fire(3'd0, 3'd0, 10, "t2 hit");
    fire(3'd0, 3'd0, 0, "t3 repeat");
    fire(3'd2, 3'd3, 0, "t3 miss");
    bus.view_sel = 1'b1; seen0 = 1'b0; seen1 = 1'b0;
    check_scan(200, "t3 attack");
    chk("t3 blink toggle", {seen0, seen1}, 2'b11);
    fire(3'd7, 3'd0, 0, "t4 row inv");
    fire(3'd0, 3'd6, 0, "t4 col inv");
    bus.view_sel = 1'b0;
    check_scan(40, "t4 scan");
    fire(3'd1, 3'd1, 0, "t5 win");
    fire(3'd3, 3'd3, 0, "t5 over fire");
    check_scan(40, "t5 over scan");
    do_load('0, "zero load");
    m = '0; m[0] = 1'b1; m[6] = 1'b1;
    fire_load(3'd0, 3'd0, m);
    for (int g = 0; g < 4; g++) begin
      m = N'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      if (m == '0) m = N'(1);
      do_load(m, "rnd load");
      for (int s = 0; s < 40; s++)
        fire(3'($urandom_range(0, ROWS)), 3'($urandom_range(0, COLS)), 0, "rnd fire");
      bus.view_sel = 1'($urandom_range(0, 1));
      check_scan(24, "rnd scan");
    end
    bus.view_sel = 1'b0;
    check_scan(100, "t6 scan");
    for (int i = 0; i < SCAN * COLS && bus.m_col == 5'b00001; i++) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    model_reset();
    chk("t6 clr m_col", bus.m_col, 1);
    chk("t6 clr seg_sel", bus.seg_sel, 1);
    chk("t6 clr m_line", bus.m_line, 0);
    chk("t6 clr shots", bus.shots, 0);
    chk("t6 clr result", bus.result, 0);
    chk("t6 clr game_over", bus.game_over, 0);
    @(negedge clk) clr = 1'b1;
    check_scan(40, "post clr");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
